// File: rtl/ascon_finalization.sv
// ascon_finalization
//   Iterative Ascon-128 finalization. Folds the key into x1/x2, runs p12 one
//   round per clock, then folds the key into x3/x4 to form the 128-bit tag.
//   Optionally checks the tag against a received tag.
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, verify_i            begin (IDLE only) / enable tag comparison
//   x0_i..x4_i                   320-bit state entering finalization
//   k0_i, k1_i                   key, k0 = most-significant word
//   exp_tag0_i, exp_tag1_i       received tag
//   busy_o                       rounds in progress
//   done_o                       one-cycle pulse, tag valid from this cycle
//   tag0_o, tag1_o, tag_ok_o     tag (held until next done) and match flag
module ascon_finalization (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        verify_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  input  logic [63:0] k0_i,
  input  logic [63:0] k1_i,
  input  logic [63:0] exp_tag0_i,
  input  logic [63:0] exp_tag1_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] tag0_o,
  output logic [63:0] tag1_o,
  output logic        tag_ok_o
);

  typedef enum logic {IDLE, RUN} state_e;
  typedef logic [4:0][63:0] st_t;  // [0] = x0

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    rcon = 8'hf0;
      4'd1:    rcon = 8'he1;
      4'd2:    rcon = 8'hd2;
      4'd3:    rcon = 8'hc3;
      4'd4:    rcon = 8'hb4;
      4'd5:    rcon = 8'ha5;
      4'd6:    rcon = 8'h96;
      4'd7:    rcon = 8'h87;
      4'd8:    rcon = 8'h78;
      4'd9:    rcon = 8'h69;
      4'd10:   rcon = 8'h5a;
      4'd11:   rcon = 8'h4b;
      default: rcon = 8'h00;
    endcase
  endfunction

  // One full Ascon round: constant, bitsliced S-box, linear diffusion.
  function automatic st_t ascon_round(input st_t s, input logic [3:0] r);
    logic [63:0] a0, a1, a2, a3, a4, t0, t1, t2, t3, t4;
    a0 = s[0];
    a1 = s[1];
    a2 = s[2] ^ {56'b0, rcon(r)};
    a3 = s[3];
    a4 = s[4];
    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;
    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;
    ascon_round[0] = a0 ^ ror(a0, 19) ^ ror(a0, 28);
    ascon_round[1] = a1 ^ ror(a1, 61) ^ ror(a1, 39);
    ascon_round[2] = a2 ^ ror(a2, 1)  ^ ror(a2, 6);
    ascon_round[3] = a3 ^ ror(a3, 10) ^ ror(a3, 17);
    ascon_round[4] = a4 ^ ror(a4, 7)  ^ ror(a4, 41);
  endfunction

  state_e      state_q, state_d;
  st_t         s_q, s_d, s_rnd;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] k0_q, k0_d, k1_q, k1_d;
  logic [63:0] e0_q, e0_d, e1_q, e1_d;
  logic        ver_q, ver_d;
  logic [63:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic        ok_q, ok_d;
  logic        done_q, done_d;

  assign s_rnd = ascon_round(s_q, rnd_q);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    rnd_d   = rnd_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    ver_d   = ver_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          s_d[0]  = x0_i;
          s_d[1]  = x1_i ^ k0_i;
          s_d[2]  = x2_i ^ k1_i;
          s_d[3]  = x3_i;
          s_d[4]  = x4_i;
          k0_d    = k0_i;
          k1_d    = k1_i;
          e0_d    = exp_tag0_i;
          e1_d    = exp_tag1_i;
          ver_d   = verify_i;
          rnd_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = s_rnd;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd11) begin
          // Tag is taken straight from the last round's output so done
          // lines up with round 11 rather than one cycle after it.
          tag0_d  = s_rnd[3] ^ k0_q;
          tag1_d  = s_rnd[4] ^ k1_q;
          ok_d    = ver_q & ((s_rnd[3] ^ k0_q) == e0_q) & ((s_rnd[4] ^ k1_q) == e1_q);
          done_d  = 1'b1;
          rnd_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      rnd_q   <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      ver_q   <= 1'b0;
      tag0_q  <= '0;
      tag1_q  <= '0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rnd_q   <= rnd_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      ver_q   <= ver_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = (state_q == RUN);
  assign done_o   = done_q;
  assign tag0_o   = tag0_q;
  assign tag1_o   = tag1_q;
  assign tag_ok_o = ok_q;

endmodule

// File: tb/tb_ascon_finalization.sv
module tb_ascon_finalization;

  typedef logic [4:0][63:0] st_t;  // [0] = x0

  typedef struct {
    st_t         s;
    logic [63:0] k0, k1, e0, e1;
    logic        ver;
    logic [63:0] t0, t1;
    logic        ok;
  } vec_t;

  // Ascon 5-bit S-box, input/output bit 4 = x0.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
  localparam int ROT2 [5] = '{28, 39, 6, 17, 41};
  localparam logic [63:0] KAT_T0 = 64'hE355159F292911F7;
  localparam logic [63:0] KAT_T1 = 64'h94CB1432A0103A8A;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, verify = 1'b0;
  st_t         xin = '0;
  logic [63:0] k0 = '0, k1 = '0, e0 = '0, e1 = '0;
  logic        busy, done, tag_ok;
  logic [63:0] tag0, tag1;
  int          nchecks = 0, nerrors = 0;

  always #5 clk = ~clk;

  ascon_finalization dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .verify_i(verify),
    .x0_i(xin[0]), .x1_i(xin[1]), .x2_i(xin[2]), .x3_i(xin[3]), .x4_i(xin[4]),
    .k0_i(k0), .k1_i(k1), .exp_tag0_i(e0), .exp_tag1_i(e1),
    .busy_o(busy), .done_o(done), .tag0_o(tag0), .tag1_o(tag1), .tag_ok_o(tag_ok));

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t p12(input st_t s);
    st_t n;
    logic [4:0] o;
    for (int r = 0; r < 12; r++) begin
      s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        o = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
        for (int i = 0; i < 5; i++) n[i][b] = o[4-i];
      end
      for (int i = 0; i < 5; i++) s[i] = n[i] ^ rotr(n[i], ROT1[i]) ^ rotr(n[i], ROT2[i]);
    end
    return s;
  endfunction

  function automatic logic [127:0] ref_tag(input st_t s, input logic [63:0] a, input logic [63:0] b);
    s[1] = s[1] ^ a;
    s[2] = s[2] ^ b;
    s = p12(s);
    return {s[3] ^ a, s[4] ^ b};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input st_t s, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] d, input logic v);
    xin = s; k0 = a; k1 = b; e0 = c; e1 = d; verify = v;
  endtask

  task automatic scramble();
    for (int i = 0; i < 5; i++) xin[i] = {$urandom, $urandom};
    k0 = {$urandom, $urandom}; k1 = {$urandom, $urandom};
    e0 = {$urandom, $urandom}; e1 = {$urandom, $urandom};
    verify = 1'($urandom);
  endtask

  // Starts an operation from the current (post-edge) time; returns cycles
  // from start edge to done. Checks tag hold and busy while waiting.
  // inj >= 0 pulses a bogus start so that it is sampled at edge E+inj+1.
  task automatic do_op(input st_t s, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] d, input logic v,
                       input int inj, output int lat);
    logic [128:0] held;
    logic         bad;
    held = {tag0, tag1, tag_ok};
    bad  = 1'b0;
    drive(s, a, b, c, d, v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    lat = 0;
    while (!done && lat < 20) begin
      if (lat == inj) begin scramble(); start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (!done && ({tag0, tag1, tag_ok} != held || !busy)) bad = 1'b1;
    end
    check("hold_busy_while_running", 128'(bad), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[4];
    st_t         kat, rs;
    logic [127:0] rt;
    logic        rv, rok, seen;
    int          lat;

    // Build the KAT finalization input: init, no AD (domain sep), empty msg pad.
    kat = {64'h08090a0b0c0d0e0f, 64'h0001020304050607,
           64'h08090a0b0c0d0e0f, 64'h0001020304050607, 64'h80400c0600000000};
    kat = p12(kat);
    kat[3] = kat[3] ^ 64'h0001020304050607;
    kat[4] = kat[4] ^ 64'h08090a0b0c0d0e0f ^ 64'h1;
    kat[0] = kat[0] ^ 64'h8000000000000000;

    vecs[0] = '{kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, 64'h0, 64'h0, 1'b0, KAT_T0, KAT_T1, 1'b0};
    vecs[1] = '{kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, KAT_T0, KAT_T1, 1'b1, KAT_T0, KAT_T1, 1'b1};
    vecs[2] = '{kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, KAT_T0, KAT_T1 ^ 64'h1, 1'b1, KAT_T0, KAT_T1, 1'b0};
    vecs[3] = '{kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, KAT_T0, KAT_T1, 1'b0, KAT_T0, KAT_T1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {64'(busy), 64'(done)}, 128'(0));
    check("reset_tag", {tag0, tag1}, 128'(0));
    check("reset_tag_ok", 128'(tag_ok), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors: KAT and verify variants
    for (int i = 0; i < 4; i++) begin
      do_op(vecs[i].s, vecs[i].k0, vecs[i].k1, vecs[i].e0, vecs[i].e1, vecs[i].ver, -1, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(12));
      check($sformatf("vec%0d_tag", i), {tag0, tag1}, {vecs[i].t0, vecs[i].t1});
      check($sformatf("vec%0d_tag_ok", i), 128'(tag_ok), 128'(vecs[i].ok));
      check($sformatf("vec%0d_busy_at_done", i), 128'(busy), 128'(0));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 128'(done), 128'(0));
    end

    // Start while busy: bogus start sampled at E+5 must be ignored
    do_op(kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, KAT_T0, KAT_T1, 1'b1, 4, lat);
    check("busy_start_latency", 128'(lat), 128'(12));
    check("busy_start_tag", {tag0, tag1, 127'(0)} >> 127, {KAT_T0, KAT_T1, 127'(0)} >> 127);
    check("busy_start_tag_full", {tag0, tag1}, {KAT_T0, KAT_T1});
    check("busy_start_ok", 128'(tag_ok), 128'(1));
    seen = 1'b0;
    repeat (16) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    check("busy_start_no_second_op", 128'(seen), 128'(0));

    // Back-to-back: second start in the done cycle of the first
    rs[0] = 64'h0123456789abcdef; rs[1] = 64'hfedcba9876543210; rs[2] = 64'h0;
    rs[3] = 64'hffffffffffffffff; rs[4] = 64'h5555aaaa5555aaaa;
    rt = ref_tag(rs, 64'hdeadbeefcafef00d, 64'h0f1e2d3c4b5a6978);
    do_op(kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, 64'h0, 64'h0, 1'b0, -1, lat);
    check("b2b_first_tag", {tag0, tag1}, {KAT_T0, KAT_T1});
    do_op(rs, 64'hdeadbeefcafef00d, 64'h0f1e2d3c4b5a6978, rt[127:64], rt[63:0], 1'b1, -1, lat);
    check("b2b_second_latency", 128'(lat), 128'(12));
    check("b2b_second_tag", {tag0, tag1}, rt);
    check("b2b_second_ok", 128'(tag_ok), 128'(1));
    @(posedge clk); #1;

    // Reset mid-operation at E+6
    drive(kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, KAT_T0, KAT_T1, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy_done", {64'(busy), 64'(done)}, 128'(0));
    check("midrst_tag", {tag0, tag1}, 128'(0));
    check("midrst_tag_ok", 128'(tag_ok), 128'(0));
    seen = 1'b0;
    repeat (16) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    check("midrst_no_done", 128'(seen), 128'(0));
    do_op(kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, KAT_T0, KAT_T1, 1'b1, -1, lat);
    check("midrst_restart_latency", 128'(lat), 128'(12));
    check("midrst_restart_tag", {tag0, tag1}, {KAT_T0, KAT_T1});

    // rst and start together: rst wins
    @(posedge clk); #1;
    drive(kat, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, KAT_T0, KAT_T1, 1'b1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (16) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    check("rst_start_same_cycle", {64'(seen), tag0 | tag1}, 128'(0));

    // Randomized against the model
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 5; i++) rs[i] = {$urandom, $urandom};
      k0 = {$urandom, $urandom};
      k1 = {$urandom, $urandom};
      rt = ref_tag(rs, k0, k1);
      rv = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        e0 = rt[127:64]; e1 = rt[63:0];
      end else begin
        e0 = {$urandom, $urandom}; e1 = {$urandom, $urandom};
        if ($urandom_range(1, 0) == 1) e0 = rt[127:64];
      end
      rok = rv && ({e0, e1} == rt);
      do_op(rs, k0, k1, e0, e1, rv, -1, lat);
      check($sformatf("rand%0d_latency", n), 128'(lat), 128'(12));
      check($sformatf("rand%0d_tag", n), {tag0, tag1}, rt);
      check($sformatf("rand%0d_tag_ok", n), 128'(tag_ok), 128'(rok));
      if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
